// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the KGP_RISC core: FETCH/DECODE/EXEC/MEM/WB with branch resolution.
// Optional CTRL_PERF_EN adds busy-cycle and retired-instruction counters.
module multicycle_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic [3:0] func,
    input  logic       zero,
    input  logic       carry,
    input  logic       sign,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src,
    output logic [3:0] alu_op,
    output logic       flag_write,
    output logic       busy,
    output logic       illegal
`ifdef CTRL_PERF_EN
   ,output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    // state    | meaning
    // IDLE     | waiting for run
    // FETCH    | instruction request until imem_ack
    // DECODE   | opcode legality check
    // EXEC     | ALU setup / branch resolution
    // MEM      | data request until dmem_ack
    // WB       | register-file write
    // HALT     | illegal opcode seen, terminal until reset
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t     state_q, state_d, next_fetch;
    logic       imem_req_q, imem_req_d;
    logic       dmem_req_q, dmem_req_d;
    logic       dmem_we_q, dmem_we_d;
    logic       reg_write_q, reg_write_d;
    logic [1:0] wb_sel_q, wb_sel_d;
    logic       alu_src_q, alu_src_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic       flag_write_q, flag_write_d;
    logic       busy_q, busy_d;
    logic       illegal_q, illegal_d;
    logic       br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (func)
            4'b0000: br_taken = 1'b1;
            4'b0001: br_taken = zero;
            4'b0010: br_taken = ~zero;
            4'b0011: br_taken = carry;
            4'b0100: br_taken = ~carry;
            4'b0101: br_taken = sign;
            4'b0110: br_taken = ~sign;
            4'b0111: br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        next_fetch = run ? S_FETCH : S_IDLE;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode >= 3'd5) begin
                    illegal_d = 1'b1;
                    state_d   = ILLEGAL_HALT ? S_HALT : next_fetch;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    3'b000, 3'b001: state_d = S_WB;
                    3'b010:         state_d = S_MEM;
                    3'b011:         state_d = (func == 4'b0111) ? S_WB : next_fetch;
                    default:        state_d = next_fetch;
                endcase
            end
            S_MEM:    if (dmem_ack) state_d = func[0] ? next_fetch : S_WB;
            S_WB:     state_d = next_fetch;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        // Moore strobes are computed from the state being entered so they register with it.
        imem_req_d   = (state_d == S_FETCH);
        dmem_req_d   = (state_d == S_MEM);
        dmem_we_d    = (state_d == S_MEM) && func[0];
        reg_write_d  = (state_d == S_WB);
        busy_d       = (state_d != S_IDLE) && (state_d != S_HALT);
        alu_op_d     = 4'b0000;
        alu_src_d    = 1'b0;
        flag_write_d = 1'b0;
        wb_sel_d     = 2'b00;
        if (state_d == S_EXEC) begin
            case (opcode)
                3'b000: begin
                    alu_op_d     = func;
                    flag_write_d = 1'b1;
                end
                3'b001: begin
                    alu_op_d     = {2'b00, func[1:0]};
                    alu_src_d    = 1'b1;
                    flag_write_d = 1'b1;
                end
                3'b010:  alu_src_d = 1'b1;
                default: alu_op_d  = 4'b0000;
            endcase
        end
        if (state_d == S_WB) begin
            if (state_q == S_MEM)       wb_sel_d = 2'b01;
            else if (opcode == 3'b011)  wb_sel_d = 2'b10;
            else                        wb_sel_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            wb_sel_q     <= 2'b00;
            alu_src_q    <= 1'b0;
            alu_op_q     <= 4'b0000;
            flag_write_q <= 1'b0;
            busy_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            reg_write_q  <= reg_write_d;
            wb_sel_q     <= wb_sel_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            flag_write_q <= flag_write_d;
            busy_q       <= busy_d;
            illegal_q    <= illegal_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign reg_write  = reg_write_q;
    assign wb_sel     = wb_sel_q;
    assign alu_src    = alu_src_q;
    assign alu_op     = alu_op_q;
    assign flag_write = flag_write_q;
    assign busy       = busy_q;
    assign illegal    = illegal_q;

    // PC strobes must act in the same cycle as the ack / flag sample, so they bypass the registers.
    assign ir_write = (state_q == S_FETCH) && imem_ack;
    assign pc_write = ir_write ||
                      ((state_q == S_EXEC) && (((opcode == 3'b011) && br_taken) || (opcode == 3'b100)));
    assign pc_src   = (state_q != S_EXEC)                  ? 2'b00 :
                      (opcode == 3'b100)                   ? 2'b10 :
                      ((opcode == 3'b011) && br_taken)     ? 2'b01 : 2'b00;

`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic        instr_done;

    always_comb begin
        instr_done  = (state_q == S_WB) ||
                      (((state_q == S_EXEC) || (state_q == S_MEM)) &&
                       ((state_d == S_FETCH) || (state_d == S_IDLE)));
        cycle_cnt_d = cycle_cnt_q + {31'd0, busy_q};
        instr_cnt_d = instr_cnt_q + {31'd0, instr_done};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle expected strobes, a negedge
// monitor pops and compares them on every busy cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst, run, zero, carry, sign, imem_ack, dmem_ack;
    logic [2:0] opcode;
    logic [3:0] func;
    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write;
    logic       alu_src, flag_write, busy, illegal;
    logic [1:0] pc_src, wb_sel;
    logic [3:0] alu_op;
`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .func(func),
        .zero(zero), .carry(carry), .sign(sign),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_src(alu_src),
        .alu_op(alu_op), .flag_write(flag_write), .busy(busy), .illegal(illegal)
`ifdef CTRL_PERF_EN
       ,.cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       flag_write, busy, illegal;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
    } ent_t;

    obs_t act;
    assign act = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write,
                  wb_sel, alu_src, alu_op, flag_write, busy, illegal};

    ent_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   ill_exp = 1'b0;

    task automatic check(input string name, input obs_t got, input obs_t want);
        logic [17:0] g, w;
        g = got;
        w = want;
        n_tests++;
        if (g !== w) begin
            n_fail++;
            $display("FAIL %s: got %05h required %05h", name, g, w);
        end
    endtask

    task automatic check_int(input string name, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        ent_t e;
        logic [17:0] g;
        if (rst === 1'b0 && busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                g = act;
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_busy: got %05h required idle", g);
            end else begin
                e = exp_q.pop_front();
                check(e.tag, act, e.o);
            end
        end
    end

    function automatic obs_t base();
        obs_t o;
        o         = '0;
        o.busy    = 1'b1;
        o.illegal = ill_exp;
        return o;
    endfunction

    task automatic cyc(input string tag, input obs_t o, input bit ia, input bit da, input bit rn);
        ent_t e;
        @(posedge clk);
        #1;
        imem_ack = ia;
        dmem_ack = da;
        run      = rn;
        e.o      = o;
        e.tag    = tag;
        exp_q.push_back(e);
    endtask

    task automatic start();
        @(posedge clk);
        #1;
        run = 1'b1;
    endtask

    // One instruction, cycle by cycle. aop is the hand-computed alu_op for EXEC,
    // taken the hand-resolved branch outcome; last drops run in the final state.
    task automatic instr(input string nm, input logic [2:0] op, input logic [3:0] fn,
                         input int iw, input int dw, input bit z, input bit c, input bit s,
                         input bit taken, input logic [3:0] aop, input bit last);
        obs_t o;
        bit   fin;
        o          = base();
        o.imem_req = 1'b1;
        for (int i = 0; i < iw; i++) begin
            cyc({nm, ".fetch_wait"}, o, 1'b0, 1'b0, 1'b1);
            opcode = op; func = fn; zero = z; carry = c; sign = s;
        end
        o.ir_write = 1'b1;
        o.pc_write = 1'b1;
        cyc({nm, ".fetch"}, o, 1'b1, 1'b0, 1'b1);
        opcode = op; func = fn; zero = z; carry = c; sign = s;
        cyc({nm, ".decode"}, base(), 1'b0, 1'b0, 1'b1);
        o = base();
        case (op)
            3'b000: begin o.alu_op = aop; o.flag_write = 1'b1; end
            3'b001: begin o.alu_op = aop; o.alu_src = 1'b1; o.flag_write = 1'b1; end
            3'b010: begin o.alu_op = aop; o.alu_src = 1'b1; end
            3'b011: begin o.pc_write = taken; o.pc_src = taken ? 2'b01 : 2'b00; end
            default: begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
        endcase
        fin = (op == 3'b011 && fn != 4'b0111) || (op == 3'b100);
        cyc({nm, ".exec"}, o, 1'b0, op == 3'b010, !(last && fin));
        if (op == 3'b010) begin
            for (int i = 0; i <= dw; i++) begin
                o          = base();
                o.dmem_req = 1'b1;
                o.dmem_we  = fn[0];
                fin        = fn[0] && (i == dw);
                cyc({nm, ".mem"}, o, 1'b0, i == dw, !(last && fin));
            end
        end
        if (op == 3'b000 || op == 3'b001 || (op == 3'b010 && !fn[0]) ||
            (op == 3'b011 && fn == 4'b0111)) begin
            o           = base();
            o.reg_write = 1'b1;
            o.wb_sel    = (op == 3'b010) ? 2'b01 : (op == 3'b011) ? 2'b10 : 2'b00;
            cyc({nm, ".wb"}, o, 1'b0, 1'b0, !last);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t w;
        rst = 1'b1; run = 1'b0; opcode = '0; func = '0;
        zero = 1'b0; carry = 1'b0; sign = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", act, '0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", act, '0);

`ifdef CTRL_PERF_EN
        start();
        instr("perf0", 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        instr("perf1", 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        instr("perf2", 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
        repeat (3) @(posedge clk);
        #1;
        check_int("perf_instr_cnt", instr_cnt, 3);
        check_int("perf_cycle_cnt", cycle_cnt, 12);
`endif

        start();
        instr("rtype_add",  3'b000, 4'b0010, 0, 0, 0, 0, 0, 0, 4'b0010, 0);
        instr("imm",        3'b001, 4'b1110, 0, 0, 0, 0, 0, 0, 4'b0010, 0);
        instr("rtype_wait", 3'b000, 4'b1011, 2, 0, 0, 0, 0, 0, 4'b1011, 0);
        instr("load_w3",    3'b010, 4'b0000, 0, 3, 0, 0, 0, 0, 4'b0000, 0);
        instr("store",      3'b010, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        instr("beq_z1",     3'b011, 4'b0001, 0, 0, 1, 0, 0, 1, 4'b0000, 0);
        instr("beq_z0",     3'b011, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        instr("bl",         3'b011, 4'b0111, 0, 0, 0, 0, 0, 1, 4'b0000, 0);
        instr("br_f8",      3'b011, 4'b1000, 0, 0, 1, 1, 1, 0, 4'b0000, 0);
        instr("bnc_c0",     3'b011, 4'b0100, 0, 0, 0, 0, 0, 1, 4'b0000, 0);
        instr("bns_s1",     3'b011, 4'b0110, 0, 0, 0, 0, 1, 0, 4'b0000, 0);
        instr("jr",         3'b100, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_run_low", act, '0);

        // Illegal opcode: HALT with sticky illegal, run ignored.
        start();
        w = base(); w.imem_req = 1'b1; w.ir_write = 1'b1; w.pc_write = 1'b1;
        cyc("ill.fetch", w, 1'b1, 1'b0, 1'b1);
        opcode = 3'b110; func = 4'b0000;
        cyc("ill.decode", base(), 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        ill_exp   = 1'b1;
        w         = '0;
        w.illegal = 1'b1;
        check("halt_state", act, w);
        repeat (5) @(posedge clk);
        #1;
        check("halt_ignores_run", act, w);
        rst = 1'b1; ill_exp = 1'b0;
        #1;
        check("reset_from_halt", act, '0);
        run = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_halt_reset", act, '0);

        // Reset while a data request is outstanding.
        start();
        w = base(); w.imem_req = 1'b1; w.ir_write = 1'b1; w.pc_write = 1'b1;
        cyc("rmem.fetch", w, 1'b1, 1'b0, 1'b1);
        opcode = 3'b010; func = 4'b0000;
        cyc("rmem.decode", base(), 1'b0, 1'b0, 1'b1);
        w = base(); w.alu_src = 1'b1;
        cyc("rmem.exec", w, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        w = base(); w.dmem_req = 1'b1;
        check("rmem.mem_before_reset", act, w);
        #1;
        rst = 1'b1;
        #1;
        check("rmem.dmem_req_drop", act, '0);
        run = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        start();
        instr("after_reset", 3'b000, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0001, 1);
        repeat (3) @(posedge clk);
        #1;
        check_int("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
